// File: rtl/aes128_enc_seq_if.sv
// Handshake bundle for the sequenced AES-128 encryptor: plaintext/key request
// channel, ciphertext response channel and the busy indicator.
interface aes128_enc_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes128_enc_seq.sv
// Sequenced AES-128 encryptor built from aes32esmi/aes32esi byte steps, one step per cycle.
// Optional macro AES_ENC_COLUMN_PAR_EN chains four steps so a whole column completes per cycle.
module aes128_enc_seq (
  input  logic            clk,
  input  logic            rst_n,
  aes128_enc_seq_if.slave bus
);

`ifdef AES_ENC_COLUMN_PAR_EN
  localparam int LANES = 4;
`else
  localparam int LANES = 1;
`endif

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  state_t         state_reg, state_next;
  logic [127:0]   key_q;
  logic [31:0]    t   [4];
  logic [31:0]    nxt [4];
  logic [31:0]    acc;
  logic [3:0]     rnd;
  logic [1:0]     col;
  logic [1:0]     bs;
  logic [127:0]   ct_reg;

  logic [1407:0]  fullkeys;
  logic [7:0]     kx_rc;
  logic [31:0]    kx_tmp;
  logic [31:0]    rk;
  logic [31:0]    lane_rd [LANES];
  logic [31:0]    rd;
  logic           last_byte;
  logic           last_step;
  logic           in_ready_c, out_valid_c, busy_c;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Words hold row 0 in bits [31:24]; bsel picks the row and rotates the
  // column contribution into place (rotate right by 8*bsel).
  function automatic logic [31:0] aes32_step(input logic [31:0] rs1, input logic [31:0] rs2,
                                             input logic [1:0] bsel, input logic mix);
    logic [7:0]  so;
    logic [31:0] contrib;
    logic [31:0] rot;
    so      = sbox(rs2[{~bsel, 3'b000} +: 8]);
    contrib = mix ? {xtime(so), so, so, xtime(so) ^ so} : {so, 24'h000000};
    case (bsel)
      2'd0:    rot = contrib;
      2'd1:    rot = {contrib[7:0],  contrib[31:8]};
      2'd2:    rot = {contrib[15:0], contrib[31:16]};
      default: rot = {contrib[23:0], contrib[31:24]};
    endcase
    return rs1 ^ rot;
  endfunction

  function automatic logic [31:0] aes32esmi(input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [1:0] bsel);
    return aes32_step(rs1, rs2, bsel, 1'b1);
  endfunction

  function automatic logic [31:0] aes32esi(input logic [31:0] rs1, input logic [31:0] rs2,
                                           input logic [1:0] bsel);
    return aes32_step(rs1, rs2, bsel, 1'b0);
  endfunction

  // keyExpansion: word i of the schedule sits at fullkeys[32*i +: 32].
  always_comb begin
    fullkeys = '0;
    kx_rc    = 8'h01;
    kx_tmp   = '0;
    for (int i = 0; i < 4; i++)
      fullkeys[32*i +: 32] = key_q[96-32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      kx_tmp = fullkeys[32*(i-1) +: 32];
      if (i % 4 == 0) begin
        kx_tmp = subword({kx_tmp[23:0], kx_tmp[31:24]}) ^ {kx_rc, 24'h000000};
        kx_rc  = xtime(kx_rc);
      end
      fullkeys[32*i +: 32] = fullkeys[32*(i-4) +: 32] ^ kx_tmp;
    end
  end

  assign rk = fullkeys[{rnd, col, 5'b00000} +: 32];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [1:0]  bsel;
      logic [1:0]  widx;
      logic [31:0] rs1;
      logic [31:0] rs2;
      assign bsel = bs + 2'(gi);
      assign widx = col + bsel;
      assign rs2  = t[widx];
      if (gi == 0) begin : g_head
        assign rs1 = (bs == 2'd0) ? rk : acc;
      end else begin : g_chain
        assign rs1 = lane_rd[gi-1];
      end
      assign lane_rd[gi] = (rnd < 4'd10) ? aes32esmi(rs1, rs2, bsel) : aes32esi(rs1, rs2, bsel);
    end
  endgenerate

  assign rd        = lane_rd[LANES-1];
  assign last_byte = (bs + 2'(LANES - 1)) == 2'd3;
  assign last_step = last_byte && (col == 2'd3) && (rnd == 4'd10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = LOAD;
      LOAD:                       state_next = ROUND;
      ROUND:   if (last_step)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_reg)
      IDLE:    in_ready_c  = 1'b1;
      LOAD:    busy_c      = 1'b1;
      ROUND:   busy_c      = 1'b1;
      DONE:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.busy       = busy_c;
  assign bus.ciphertext = ct_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '0;
      acc    <= '0;
      rnd    <= '0;
      col    <= '0;
      bs     <= '0;
      ct_reg <= '0;
      for (int i = 0; i < 4; i++) begin
        t[i]   <= '0;
        nxt[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: if (bus.in_valid) begin
          key_q <= bus.key;
          for (int i = 0; i < 4; i++)
            t[i] <= bus.plaintext[96-32*i +: 32];
        end
        LOAD: begin
          for (int i = 0; i < 4; i++)
            t[i] <= t[i] ^ fullkeys[32*i +: 32];
          rnd <= 4'd1;
          col <= 2'd0;
          bs  <= 2'd0;
        end
        ROUND: begin
          acc <= rd;
          bs  <= bs + 2'(LANES);
          if (last_byte) begin
            nxt[col] <= rd;
            col      <= col + 2'd1;
            // Column 3 closes the round: the last word bypasses nxt.
            if (col == 2'd3) begin
              for (int i = 0; i < 3; i++)
                t[i] <= nxt[i];
              t[3] <= rd;
              rnd  <= rnd + 4'd1;
              if (rnd == 4'd10)
                ct_reg <= {nxt[0], nxt[1], nxt[2], rd};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_enc_seq.sv
// Self-checking bench for aes128_enc_seq: FIPS-197 vectors, random blocks against a
// byte-array AES model, backpressure, busy-time inputs, mid-run reset and round trip.
module tb_aes128_enc_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes128_enc_seq_if bus();

  aes128_enc_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef AES_ENC_COLUMN_PAR_EN
  localparam int LAT = 41;
`else
  localparam int LAT = 161;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] c1_ct_seen;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8), then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [1407:0] ref_keys(input logic [127:0] key);
    logic [7:0] k [176];
    logic [7:0] tmp [4];
    logic [7:0] rc, t0;
    logic [1407:0] packed_k;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) k[i] = key[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = k[i-4+j];
      if (i % 16 == 0) begin
        t0 = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[t0];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) k[i+j] = k[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 176; i++) packed_k[8*i +: 8] = k[i];
    return packed_k;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [1407:0] ks;
    logic [7:0] s [16];
    logic [7:0] ns [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] ct;
    ks = ref_keys(key);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[8*i +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) ns[w+4*c] = s[w + 4*((c+w)%4)];
      for (int i = 0; i < 16; i++) s[i] = ns[i];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[8*(16*r+i) +: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [1407:0] ks;
    logic [7:0] s [16];
    logic [7:0] ns [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] pt;
    ks = ref_keys(key);
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ ks[8*(160+i) +: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) ns[w + 4*((c+w)%4)] = s[w+4*c];
      for (int i = 0; i < 16; i++) s[i] = isb[ns[i]] ^ ks[8*(16*r+i) +: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) pt[127-8*i -: 8] = s[i];
    return pt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Offers one block, scrambles the inputs after acceptance, waits for out_valid
  // (bounded) and completes the output handshake.
  task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                           output logic [127:0] c, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 400) begin tick(); guard++; end
    bus.key = k; bus.plaintext = p; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.key = ~k; bus.plaintext = ~p;
    lat = 0;
    while (!bus.out_valid && lat < 400) begin tick(); lat++; end
    c = bus.ciphertext;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.ciphertext !== 128'h0) begin n_err++; $display("FAIL reset_ct: got %h want 0", bus.ciphertext); end
    $display("reset: in_ready=%b out_valid=%b busy=%b ct=%h", bus.in_ready, bus.out_valid, bus.busy, bus.ciphertext);
  endtask

  task automatic test_fips_c1();
    logic [127:0] c;
    int lat;
    run_block(C1_KEY, C1_PT, c, lat);
    c1_ct_seen = c;
    n_cmp++; if (c !== C1_CT) begin n_err++; $display("FAIL c1_ct: got %h want %h", c, C1_CT); end
    n_cmp++; if (c !== ref_encrypt(C1_KEY, C1_PT)) begin n_err++; $display("FAIL c1_model: got %h want %h", c, ref_encrypt(C1_KEY, C1_PT)); end
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL c1_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL c1_after_hs: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    n_cmp++; if (bus.ciphertext !== C1_CT) begin n_err++; $display("FAIL c1_retain: got %h want %h", bus.ciphertext, C1_CT); end
    $display("c1: ct=%h latency=%0d", c, lat);
  endtask

  task automatic test_fips_b();
    logic [127:0] c;
    int lat;
    run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, c, lat);
    n_cmp++; if (c !== 128'h3925841d02dc09fbdc118597196a0b32) begin n_err++; $display("FAIL b_ct: got %h want 3925841d02dc09fbdc118597196a0b32", c); end
    $display("appendix_b: ct=%h latency=%0d", c, lat);
  endtask

  task automatic test_backpressure();
    localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    int lat;
    bus.key = '0; bus.plaintext = '0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 400) begin tick(); lat++; end
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (bus.ciphertext !== ZERO_CT || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got ct=%h in_ready=%b out_valid=%b want ct=%h in_ready=0 out_valid=1",
                 i, bus.ciphertext, bus.in_ready, bus.out_valid, ZERO_CT);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got in_ready=%b want 1", bus.in_ready); end
    $display("backpressure: ct=%h held 20 cycles", bus.ciphertext);
  endtask

  task automatic test_random();
    logic [127:0] k, p, c, e;
    int lat;
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block(k, p, c, lat);
      e = ref_encrypt(k, p);
      n_cmp++; if (c !== e || lat != LAT) begin n_err++; $display("FAIL rand[%0d]: got ct=%h lat=%0d want ct=%h lat=%0d", n, c, lat, e, LAT); end
      $display("random[%0d]: key=%h pt=%h ct=%h", n, k, p, c);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] pend [$];
    logic [127:0] k, p, e;
    int accepts, done, cyc, last_acc;
    accepts = 0; done = 0; cyc = 0; last_acc = -1;
    bus.out_ready = 1'b1;
    while (done < 3 && cyc < 1000) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      bus.key = k; bus.plaintext = p; bus.in_valid = 1'b1;
      if (bus.out_valid) begin
        n_cmp++;
        if (pend.size() != 1) begin n_err++; $display("FAIL b2b_pending: got %0d want 1", pend.size()); end
        if (pend.size() > 0) begin
          e = ref_encrypt(pend[0][255:128], pend[0][127:0]);
          void'(pend.pop_front());
          n_cmp++; if (bus.ciphertext !== e) begin n_err++; $display("FAIL b2b_ct[%0d]: got %h want %h", done, bus.ciphertext, e); end
          $display("b2b completion %0d: ct=%h", done, bus.ciphertext);
        end
        done++;
      end
      if (bus.in_ready) begin
        if (last_acc >= 0) begin
          n_cmp++; if (cyc - last_acc != LAT + 2) begin n_err++; $display("FAIL b2b_gap: got %0d want %0d", cyc - last_acc, LAT + 2); end
        end
        last_acc = cyc;
        pend.push_back({k, p});
        accepts++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_cmp++; if (done != 3) begin n_err++; $display("FAIL b2b_done: got %0d completions want 3", done); end
    n_cmp++; if (accepts != done) begin n_err++; $display("FAIL b2b_accepts: got %0d want %0d", accepts, done); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] c;
    int lat, seen;
    bus.key = C1_KEY; bus.plaintext = C1_PT; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < (LAT + 1) / 2; i++) tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ciphertext !== 128'h0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got in_ready=%b out_valid=%b busy=%b ct=%h want 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.ciphertext);
    end
    tick(); tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_no_out_valid: got %0d cycles want 0", seen); end
    run_block(C1_KEY, C1_PT, c, lat);
    n_cmp++; if (c !== C1_CT || lat != LAT) begin n_err++; $display("FAIL mid_rerun: got ct=%h lat=%0d want ct=%h lat=%0d", c, lat, C1_CT, LAT); end
    $display("reset_mid: rerun ct=%h latency=%0d", c, lat);
  endtask

  task automatic test_roundtrip();
    logic [127:0] p;
    p = ref_decrypt(C1_KEY, c1_ct_seen);
    n_cmp++; if (p !== C1_PT) begin n_err++; $display("FAIL roundtrip: got %h want %h", p, C1_PT); end
    $display("roundtrip: ct=%h -> pt=%h", c1_ct_seen, p);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.key = '0; bus.plaintext = '0;
    c1_ct_seen = '0;
    build_sbox();
    do_reset();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
